// File: rtl/fullass_accum_if.sv
// -----------------------------------------------------------------------------
// fullass_accum_if
// Handshake bundle for the fullass_accum accumulator stage.
//   in_valid  : producer -> accumulator, sample valid
//   in_ready  : accumulator -> producer, sample accepted this cycle
//   in_data   : producer -> accumulator, N-bit unsigned operand
//   in_sub    : producer -> accumulator, 1 = subtract in_data, 0 = add
//   out_valid : accumulator -> consumer, frame result available
//   out_ready : consumer -> accumulator, consumer takes the result
//   out_data  : accumulator -> consumer, accumulated result
//   out_ovf   : accumulator -> consumer, sticky overflow/borrow of the frame
// Modports: master = environment side, slave = accumulator side.
// -----------------------------------------------------------------------------
interface fullass_accum_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fullass_accum.sv
// -----------------------------------------------------------------------------
// fullass_accum
// Accumulates COUNT add/subtract samples through an N-bit ripple-carry chain
// of fullass cells, then offers the frame result on a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : fullass_accum_if.slave (in_valid/in_ready/in_data/in_sub,
//          out_valid/out_ready/out_data/out_ovf)
// Parameters: N (datapath width, >= 2), COUNT (samples per frame, >= 1).
// Build option: define FULLASS_ACCUM_SAT_EN for saturating accumulation
// (add overflow clamps to all-ones, subtract borrow clamps to zero);
// otherwise the accumulator wraps modulo 2^N. The sticky flag is set either way.
// -----------------------------------------------------------------------------

// One-bit full adder cell of the ripple chain.
module fullass (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
endmodule

module fullass_accum #(
  parameter int N     = 8,
  parameter int COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  fullass_accum_if.slave    bus
);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           state_q;
  logic [N-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [N-1:0]     b_s;
  logic [N-1:0]     sum_s;
  logic [N:1]       carry_s;
  logic             ovf_now_s;
  logic [N-1:0]     acc_d;
  logic             accept_s;

  // Operand B: subtraction feeds the inverted operand with carry-in 1 (two's complement).
  always_comb begin
    b_s = bus.in_data;
    if (bus.in_sub) begin
      b_s = ~bus.in_data;
    end else begin
      b_s = bus.in_data;
    end
  end

  // Ripple chain: head takes the external carry-in, tail produces the carry-out.
  fullass u_head (
    .a_i     (acc_q[0]),
    .b_i     (b_s[0]),
    .carry_i (bus.in_sub),
    .sum_o   (sum_s[0]),
    .carry_o (carry_s[1])
  );

  for (genvar gi = 1; gi < N - 1; gi++) begin : g_mid
    fullass u_mid (
      .a_i     (acc_q[gi]),
      .b_i     (b_s[gi]),
      .carry_i (carry_s[gi]),
      .sum_o   (sum_s[gi]),
      .carry_o (carry_s[gi+1])
    );
  end

  fullass u_tail (
    .a_i     (acc_q[N-1]),
    .b_i     (b_s[N-1]),
    .carry_i (carry_s[N-1]),
    .sum_o   (sum_s[N-1]),
    .carry_o (carry_s[N])
  );

  // Per-sample out-of-range detect and next accumulator value.
  always_comb begin
    ovf_now_s = 1'b0;
    acc_d     = sum_s;
    // A subtract without carry-out means the result went below zero.
    if (bus.in_sub) begin
      ovf_now_s = ~carry_s[N];
    end else begin
      ovf_now_s = carry_s[N];
    end
`ifdef FULLASS_ACCUM_SAT_EN
    if (ovf_now_s) begin
      if (bus.in_sub) begin
        acc_d = {N{1'b0}};
      end else begin
        acc_d = {N{1'b1}};
      end
    end else begin
      acc_d = sum_s;
    end
`else
    acc_d = sum_s;
`endif
  end

  assign accept_s = bus.in_valid & in_ready_q;

  // Frame FSM with accumulator, sample counter, sticky flag and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= {N{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept_s) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | ovf_now_s;
            if (cnt_q == CNT_LAST) begin
              cnt_q       <= {CNT_W{1'b0}};
              state_q     <= ST_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1'b1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            acc_q       <= {N{1'b0}};
            ovf_q       <= 1'b0;
            state_q     <= ST_ACC;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          acc_q       <= {N{1'b0}};
          cnt_q       <= {CNT_W{1'b0}};
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;
endmodule
